// File: rtl/flash_read_ctrl_if.sv
// Read-request bus between the boot path and the NOR flash read controller.
// The bootloader is the master; flash_read_ctrl is the slave.
interface flash_read_ctrl_if;
    logic        req;
    logic [21:0] addr;
    logic        ready;
    logic        busy;
    logic [15:0] data_out;
    logic        data_valid;

    modport slave (
        input  req,
        input  addr,
        output ready,
        output busy,
        output data_out,
        output data_valid
    );

    modport master (
        output req,
        output addr,
        input  ready,
        input  busy,
        input  data_out,
        input  data_valid
    );
endinterface

// File: rtl/flash_read_ctrl.sv
// Parallel NOR flash (16-bit word mode) read sequencer for the boot path:
// RP# pulse, one Read-Array command, then single-word reads on request.
module flash_read_ctrl #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned RP_CYCLES   = 8
) (
    input  logic                clk,
    input  logic                rst,
    flash_read_ctrl_if.slave    bus,
    output logic [22:0]         flash_addr,
    inout  wire  [15:0]         flash_data,
    output logic                flash_byte,
    output logic                flash_vpen,
    output logic                flash_ce,
    output logic                flash_oe,
    output logic                flash_we,
    output logic                flash_rp
);

    localparam int unsigned CNT_MAX = (WAIT_CYCLES > RP_CYCLES) ? WAIT_CYCLES : RP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t RP_LAST   = cnt_t'(RP_CYCLES - 1);
    localparam cnt_t WAIT_LAST = cnt_t'(WAIT_CYCLES - 1);
    localparam cnt_t CNT_TOP   = cnt_t'(CNT_MAX);
    localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;

    typedef enum logic [2:0] {
        RST_WAIT,
        CMD,
        CMD_HOLD,
        IDLE,
        READ
    } state_t;

    state_t      state_q;
    cnt_t        cnt_q;
    cnt_t        cnt_inc;
    logic        ce_q;
    logic        oe_q;
    logic        we_q;
    logic        rp_q;
    logic        drv_q;
    logic        ready_q;
    logic        busy_q;
    logic        valid_q;
    logic [15:0] dout_q;
    logic [22:0] faddr_q;

    // Saturating step keeps the counter from wrapping if a phase is ever mis-sequenced.
    assign cnt_inc = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + cnt_t'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_WAIT;
            cnt_q   <= '0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            rp_q    <= 1'b0;
            drv_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            faddr_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                RST_WAIT: begin
                    if (cnt_q == RP_LAST) begin
                        rp_q    <= 1'b1;
                        ce_q    <= 1'b0;
                        we_q    <= 1'b0;
                        drv_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= CMD;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                CMD: begin
                    if (cnt_q == WAIT_LAST) begin
                        we_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= CMD_HOLD;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                CMD_HOLD: begin
                    // Data is held one cycle past WE# rising before the bus is released.
                    ce_q    <= 1'b1;
                    drv_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                IDLE: begin
                    if (bus.req) begin
                        faddr_q <= {bus.addr, 1'b0};
                        busy_q  <= 1'b1;
                        ce_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (cnt_q == WAIT_LAST) begin
                        dout_q  <= flash_data;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        ce_q    <= 1'b1;
                        oe_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= RST_WAIT;
                end
            endcase
        end
    end

    assign flash_data = drv_q ? READ_ARRAY_CMD : 'z;

    assign flash_addr = faddr_q;
    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_ce   = ce_q;
    assign flash_oe   = oe_q;
    assign flash_we   = we_q;
    assign flash_rp   = rp_q;

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Randomized bench for flash_read_ctrl against a timeline model of the
// init sequence and read transactions, with a behavioural flash array.
module tb_flash_read_ctrl;

    localparam int WAIT = 4;
    localparam int RP   = 8;
    localparam int T_RDY = RP + WAIT + 1;
    localparam int NCYC  = 4000;

    logic        clk;
    logic        rst;
    wire  [15:0] flash_data;
    logic [22:0] flash_addr;
    logic        flash_byte;
    logic        flash_vpen;
    logic        flash_ce;
    logic        flash_oe;
    logic        flash_we;
    logic        flash_rp;

    flash_read_ctrl_if bus ();

    flash_read_ctrl #(
        .WAIT_CYCLES (WAIT),
        .RP_CYCLES   (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_byte (flash_byte),
        .flash_vpen (flash_vpen),
        .flash_ce   (flash_ce),
        .flash_oe   (flash_oe),
        .flash_we   (flash_we),
        .flash_rp   (flash_rp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [21:0] a);
        if (a == 22'h000123) return 16'hBEEF;
        return a[15:0] ^ {a[21:16], 10'h2A5} ^ 16'h5A3C;
    endfunction

    // Flash device: drives the bus only while both CE# and OE# are low.
    assign flash_data = (!flash_ce && !flash_oe) ? mem_word(flash_addr[22:1]) : 16'bz;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Model: t = edges since the last reset edge; a = edge of the latest accepted read.
    int          t;
    bit          have_a;
    int          a;
    logic [21:0] a_addr;
    logic [15:0] exp_dout;
    logic [22:0] exp_faddr;

    function automatic bit m_busy();
        return have_a && (t < a + WAIT);
    endfunction

    function automatic bit m_dv();
        return have_a && (t == a + WAIT);
    endfunction

    task automatic model_step(input logic r, input logic rq, input logic [21:0] ad);
        bit rdy_before;
        bit busy_before;
        if (r) begin
            t = 0;
            have_a = 0;
            exp_dout = '0;
            exp_faddr = '0;
            return;
        end
        rdy_before  = (t >= T_RDY);
        busy_before = m_busy();
        t++;
        if (rdy_before && !busy_before && rq) begin
            have_a = 1;
            a = t;
            a_addr = ad;
            exp_faddr = {ad, 1'b0};
        end
        if (have_a && t == a + WAIT) exp_dout = mem_word(a_addr);
    endtask

    task automatic compare_outputs();
        bit cmdwin;
        bit rdwin;
        cmdwin = (t >= RP) && (t <= RP + WAIT);
        rdwin  = m_busy();
        check("rp",         32'(flash_rp),        32'(t >= RP));
        check("we",         32'(flash_we),        32'(!((t >= RP) && (t < RP + WAIT))));
        check("ce",         32'(flash_ce),        32'(!(cmdwin || rdwin)));
        check("oe",         32'(flash_oe),        32'(!rdwin));
        check("ready",      32'(bus.ready),       32'(t >= T_RDY));
        check("busy",       32'(bus.busy),        32'(rdwin));
        check("data_valid", 32'(bus.data_valid),  32'(m_dv()));
        check("data_out",   32'(bus.data_out),    32'(exp_dout));
        check("flash_addr", 32'(flash_addr),      32'(exp_faddr));
        check("flash_byte", 32'(flash_byte),      32'h1);
        check("flash_vpen", 32'(flash_vpen),      32'h1);
        if (cmdwin) check("cmd_data", 32'(flash_data), 32'h00FF);
    endtask

    initial begin
        int  rst_left;
        int  mode;
        bit  forced;
        rst = 1'b1;
        bus.req = 1'b0;
        bus.addr = '0;
        t = 0;
        have_a = 0;
        a = 0;
        a_addr = '0;
        exp_dout = '0;
        exp_faddr = '0;
        rst_left = 2;
        mode = 0;
        forced = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compare_outputs();

            if (cyc % 200 == 0) mode = $urandom_range(0, 2);

            if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 399) == 0) begin
                    rst = 1'b1;
                    rst_left = $urandom_range(0, 2);
                end
            end
            if (!forced && cyc > 1000 && have_a && t == a + 2) begin
                rst = 1'b1;
                forced = 1;
            end

            case (mode)
                0: begin
                    bus.req  = ($urandom_range(0, 9) < 3);
                    bus.addr = ($urandom_range(0, 7) == 0) ? 22'h000123 : 22'($urandom);
                end
                1: begin
                    bus.req = 1'b1;
                    if (m_dv()) bus.addr = bus.addr + 22'd1;
                end
                default: begin
                    bus.req  = ($urandom_range(0, 19) == 0);
                    bus.addr = 22'($urandom_range(0, 15));
                end
            endcase

            model_step(rst, bus.req, bus.addr);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
